// File: rtl/vcm_i2c_pkg.sv
// ---------------------------------------------------------------------------
// vcm_i2c_pkg
//   Shared definitions for the VCM driver I2C writer.
//   - state_e        : transaction state machine encoding
//   - NUM_BYTES      : bytes per write (address+W, data high, data low)
//   - QUARTERS_*     : SCL quarter-period bookkeeping
//   - bus_drive()    : maps (state, quarter, bit) to the open-drain enables
// ---------------------------------------------------------------------------
package vcm_i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BIT,
    ST_ACK,
    ST_STOP,
    ST_DONE
  } state_e;

  localparam int NUM_BYTES         = 3;
  localparam int QUARTERS_PER_SLOT = 4;
  // START (4) + 27 bit/ack slots (108) + STOP (4)
  localparam int QUARTERS_FULL     = 116;

  // Returns {scl_oe, sda_oe}; 1 pulls the line low, 0 releases it.
  // SDA only moves while SCL is held low, except for the START (q1) and
  // STOP (q3) conditions themselves.
  function automatic logic [1:0] bus_drive(input state_e     st,
                                           input logic [1:0] q,
                                           input logic       bit_val);
    logic [1:0] d;
    d = 2'b00;
    case (st)
      ST_START: begin
        case (q)
          2'd0:    d = 2'b00;
          2'd1:    d = 2'b01;
          2'd2:    d = 2'b01;
          default: d = 2'b11;
        endcase
      end
      ST_BIT:  d = {(q == 2'd0) || (q == 2'd3), ~bit_val};
      ST_ACK:  d = {(q == 2'd0) || (q == 2'd3), 1'b0};
      ST_STOP: begin
        case (q)
          2'd0:    d = 2'b11;
          2'd1:    d = 2'b01;
          2'd2:    d = 2'b01;
          default: d = 2'b00;
        endcase
      end
      default: d = 2'b00;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/vcm_i2c_tick_gen.sv
// ---------------------------------------------------------------------------
// vcm_i2c_tick_gen
//   Quarter-period timebase for the I2C writer.
//   clk     in  system clock
//   rst     in  asynchronous active-high reset
//   clr     in  synchronous clear (restart at quarter 0, count 0)
//   tick    out high in the last cycle of each quarter (count == CLK_DIV-1)
//   quarter out index of the current quarter within a 4-quarter slot
// ---------------------------------------------------------------------------
module vcm_i2c_tick_gen #(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  output logic       tick,
  output logic [1:0] quarter
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    quarter_q, quarter_d;

  assign tick    = (cnt_q == LAST);
  assign quarter = quarter_q;

  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    quarter_d = quarter_q;
    if (clr) begin
      cnt_d     = '0;
      quarter_d = 2'd0;
    end else if (tick) begin
      cnt_d     = '0;
      quarter_d = quarter_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      quarter_q <= 2'd0;
    end else begin
      cnt_q     <= cnt_d;
      quarter_q <= quarter_d;
    end
  end

endmodule

// File: rtl/vcm_i2c_writer.sv
// ---------------------------------------------------------------------------
// vcm_i2c_writer
//   Sends a 16-bit lens-position word to the VCM driver as one I2C write:
//   START, {DEV_ADDR,W}, VCM_DATA[15:8], VCM_DATA[7:0], STOP.
//   CLK      in  system clock
//   RESET    in  asynchronous active-high reset (releases both lines at once)
//   VCM_DATA in  word to send, sampled only when a request is taken
//   WR_REQ   in  one-cycle request strobe
//   SDA_IN   in  synchronised SDA pad level (ACK sampling)
//   SCL_OE   out 1 = pull SCL low
//   SDA_OE   out 1 = pull SDA low
//   BUSY     out transaction in progress
//   DONE     out one-cycle end-of-transaction pulse
//   ACK_ERR  out last transaction saw a NACK
//
// Request handshake: WR_REQ is a fire-and-forget strobe with no ready.
// In IDLE it starts a transaction at once; at any other time it is stored
// as a single pending word (latest wins) that starts the cycle after DONE.
// ---------------------------------------------------------------------------
module vcm_i2c_writer #(
  parameter int         CLK_DIV  = 125,
  parameter logic [6:0] DEV_ADDR = 7'h0C
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] VCM_DATA,
  input  logic        WR_REQ,
  input  logic        SDA_IN,
  output logic        SCL_OE,
  output logic        SDA_OE,
  output logic        BUSY,
  output logic        DONE,
  output logic        ACK_ERR
);

  import vcm_i2c_pkg::*;

  state_e      state_q, state_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] shift_q, shift_d;
  logic        pending_q, pending_d;
  logic [15:0] pend_data_q, pend_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ack_err_q, ack_err_d;
  logic        scl_oe_q, scl_oe_d;
  logic        sda_oe_q, sda_oe_d;

  logic        tick;
  logic [1:0]  quarter;
  logic [1:0]  next_quarter;
  logic        slot_end;
  logic        start_txn;
  logic [15:0] txn_data;

  vcm_i2c_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk     (CLK),
    .rst     (RESET),
    .clr     (start_txn),
    .tick    (tick),
    .quarter (quarter)
  );

  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    byte_idx_d  = byte_idx_q;
    shift_d     = shift_q;
    pending_d   = pending_q;
    pend_data_d = pend_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ack_err_d   = ack_err_q;

    slot_end  = tick && (quarter == 2'(QUARTERS_PER_SLOT - 1));
    // DONE doubles as an accept slot so a queued or coincident request
    // begins the very next cycle.
    start_txn = ((state_q == ST_IDLE) && WR_REQ) ||
                ((state_q == ST_DONE) && (WR_REQ || pending_q));
    txn_data  = WR_REQ ? VCM_DATA : pend_data_q;

    case (state_q)
      ST_START: begin
        if (slot_end) begin
          state_d    = ST_BIT;
          bit_idx_d  = 3'd0;
          byte_idx_d = 2'd0;
        end
      end
      ST_BIT: begin
        if (slot_end) begin
          shift_d = {shift_q[22:0], 1'b0};
          if (bit_idx_q == 3'd7) begin
            state_d = ST_ACK;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_ACK: begin
        if (tick && (quarter == 2'd2) && SDA_IN) begin
          ack_err_d = 1'b1;
        end
        // ack_err_q only reflects this transaction: it is cleared on accept.
        if (slot_end) begin
          if (ack_err_q || (byte_idx_q == 2'(NUM_BYTES - 1))) begin
            state_d = ST_STOP;
          end else begin
            state_d    = ST_BIT;
            byte_idx_d = byte_idx_q + 2'd1;
            bit_idx_d  = 3'd0;
          end
        end
      end
      ST_STOP: begin
        if (slot_end) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
      end
    endcase

    if (start_txn) begin
      state_d    = ST_START;
      shift_d    = {DEV_ADDR, 1'b0, txn_data};
      bit_idx_d  = 3'd0;
      byte_idx_d = 2'd0;
      busy_d     = 1'b1;
      ack_err_d  = 1'b0;
      pending_d  = 1'b0;
    end else if (WR_REQ) begin
      pending_d   = 1'b1;
      pend_data_d = VCM_DATA;
    end

    // Outputs are registered for the position the FSM enters next, so the
    // pins always match the current (state, quarter).
    if (start_txn) begin
      next_quarter = 2'd0;
    end else if (tick) begin
      next_quarter = quarter + 2'd1;
    end else begin
      next_quarter = quarter;
    end
    {scl_oe_d, sda_oe_d} = bus_drive(state_d, next_quarter, shift_d[23]);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      bit_idx_q   <= 3'd0;
      byte_idx_q  <= 2'd0;
      shift_q     <= 24'd0;
      pending_q   <= 1'b0;
      pend_data_q <= 16'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ack_err_q   <= 1'b0;
      scl_oe_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      byte_idx_q  <= byte_idx_d;
      shift_q     <= shift_d;
      pending_q   <= pending_d;
      pend_data_q <= pend_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ack_err_q   <= ack_err_d;
      scl_oe_q    <= scl_oe_d;
      sda_oe_q    <= sda_oe_d;
    end
  end

  assign SCL_OE  = scl_oe_q;
  assign SDA_OE  = sda_oe_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign ACK_ERR = ack_err_q;

endmodule

// File: tb/tb_vcm_i2c_writer.sv
// ---------------------------------------------------------------------------
// tb_vcm_i2c_writer
//   Directed bench for vcm_i2c_writer with CLK_DIV=4. The driver pushes the
//   expected bus bytes and per-transaction results into queues; a monitor
//   decodes the open-drain bus, models the slave ACK, checks SCL/SDA timing
//   and pops/compares on every decoded byte and every DONE pulse.
// ---------------------------------------------------------------------------
module tb_vcm_i2c_writer;

  localparam int DIV      = 4;
  localparam int FULL_LEN = 464;  // 116 quarters x 4 cycles
  localparam int NACK_LEN = 176;  // 44 quarters x 4 cycles

  typedef struct packed {
    logic [31:0] len;
    logic        err;
    logic        follow;
  } txn_t;

  // clock / reset block
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] vcm_data;
  logic        wr_req;
  logic        sda_in;
  logic        scl_oe, sda_oe, busy, done, ack_err;
  logic        slave_pull;
  logic        slave_ack_en;

  // Open-drain bus: low if either side pulls.
  assign sda_in = ~(sda_oe | slave_pull);

  vcm_i2c_writer #(
    .CLK_DIV  (DIV),
    .DEV_ADDR (7'h0C)
  ) dut (
    .CLK      (clk),
    .RESET    (rst),
    .VCM_DATA (vcm_data),
    .WR_REQ   (wr_req),
    .SDA_IN   (sda_in),
    .SCL_OE   (scl_oe),
    .SDA_OE   (sda_oe),
    .BUSY     (busy),
    .DONE     (done),
    .ACK_ERR  (ack_err)
  );

  // scoreboard
  logic [7:0] exp_q[$];
  txn_t       exp_txn_q[$];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not expected or not seen", name);
  endtask

  task automatic exp_txn(input int len, input logic err, input logic follow);
    txn_t t;
    t.len    = 32'(len);
    t.err    = err;
    t.follow = follow;
    exp_txn_q.push_back(t);
  endtask

  task automatic exp_write(input logic [15:0] d, input logic follow);
    exp_q.push_back(8'h18);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
    exp_txn(FULL_LEN, 1'b0, follow);
  endtask

  // driver tasks
  task automatic send_req(input logic [15:0] d);
    @(posedge clk); #2;
    vcm_data = d;
    wr_req   = 1'b1;
    @(posedge clk); #2;
    wr_req   = 1'b0;
    vcm_data = 16'($urandom_range(0, 65535));
  endtask

  task automatic wait_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(posedge clk); #2;
      seen = done;
    end
    if (!seen) fail_now({name, "_timeout"});
  endtask

  // monitor: protocol checker, bus decoder, slave ACK model, txn checks
  logic prev_scl, prev_sda, prev_busy;
  logic phase_valid, saw_start, in_frame;
  logic chk_follow, exp_follow;
  int   phase_cnt, bit_cnt, busy_cnt;
  logic [7:0] rx_byte;
  txn_t t_mon;

  initial begin
    slave_pull = 1'b0;
    prev_scl = 1'b0; prev_sda = 1'b0; prev_busy = 1'b0;
    phase_valid = 1'b0; saw_start = 1'b0; in_frame = 1'b0;
    chk_follow = 1'b0; exp_follow = 1'b0;
    phase_cnt = 0; bit_cnt = 0; busy_cnt = 0; rx_byte = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        phase_valid = 1'b0; saw_start = 1'b0; in_frame = 1'b0;
        chk_follow = 1'b0; bit_cnt = 0; busy_cnt = 0; phase_cnt = 0;
        slave_pull = 1'b0;
      end else begin
        // SDA may only move under a released SCL as START or STOP.
        if (!prev_scl && !scl_oe && (sda_oe != prev_sda)) begin
          if (sda_oe) begin
            check("start_framing", {31'd0, in_frame}, 32'd0);
            in_frame  = 1'b1;
            saw_start = 1'b1;
            bit_cnt   = 0;
          end else begin
            check("stop_framing", {31'd0, in_frame}, 32'd1);
            in_frame = 1'b0;
            bit_cnt  = 0;
          end
        end
        if (scl_oe != prev_scl) begin
          if (phase_valid) begin
            if (prev_scl) check("scl_low_len", phase_cnt, 2 * DIV);
            else if (!saw_start) check("scl_high_len", phase_cnt, 2 * DIV);
          end
          if (scl_oe) saw_start = 1'b0;
          phase_cnt   = 1;
          phase_valid = 1'b1;
          if (!scl_oe && in_frame) begin
            bit_cnt++;
            if (bit_cnt <= 8) rx_byte = {rx_byte[6:0], sda_in};
            if (bit_cnt == 8) begin
              if (exp_q.size() == 0) fail_now("rx_byte_unexpected");
              else check("rx_byte", rx_byte, exp_q.pop_front());
            end
            if (bit_cnt == 9) bit_cnt = 0;
          end
          if (scl_oe) slave_pull = in_frame && (bit_cnt == 8) && slave_ack_en;
        end else begin
          phase_cnt++;
        end

        if (chk_follow) begin
          check("follow_on_busy", {31'd0, busy}, {31'd0, exp_follow});
          chk_follow = 1'b0;
        end
        if (busy) begin
          if (!prev_busy) check("ack_err_cleared", {31'd0, ack_err}, 32'd0);
          busy_cnt++;
        end
        if (done) begin
          check("busy_low_in_done", {31'd0, busy}, 32'd0);
          check("stop_before_done", {31'd0, in_frame}, 32'd0);
          if (exp_txn_q.size() == 0) begin
            fail_now("unexpected_done");
          end else begin
            t_mon = exp_txn_q.pop_front();
            check("busy_len", busy_cnt, t_mon.len);
            check("ack_err", {31'd0, ack_err}, {31'd0, t_mon.err});
            chk_follow = 1'b1;
            exp_follow = t_mon.follow;
          end
          busy_cnt = 0;
        end
      end
      prev_scl  = scl_oe;
      prev_sda  = sda_oe;
      prev_busy = busy;
    end
  end

  // stimulus
  initial begin
    wr_req       = 1'b0;
    vcm_data     = 16'h0000;
    slave_ack_en = 1'b1;
    rst          = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_scl_oe",  {31'd0, scl_oe},  32'd0);
    check("rst_sda_oe",  {31'd0, sda_oe},  32'd0);
    check("rst_busy",    {31'd0, busy},    32'd0);
    check("rst_done",    {31'd0, done},    32'd0);
    check("rst_ack_err", {31'd0, ack_err}, 32'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // basic write: 0x18, 0x1A, 0x5F
    exp_write(16'h1A5F, 1'b0);
    send_req(16'h1A5F);
    wait_done("basic");

    // address NACK: only the address byte, then STOP
    slave_ack_en = 1'b0;
    exp_q.push_back(8'h18);
    exp_txn(NACK_LEN, 1'b1, 1'b0);
    send_req(16'hA5A5);
    wait_done("nack");
    slave_ack_en = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    check("ack_err_held", {31'd0, ack_err}, 32'd1);

    // two requests while busy: only the latest follows
    exp_write(16'hBEEF, 1'b1);
    exp_write(16'h0200, 1'b0);
    send_req(16'hBEEF);
    repeat (50) @(posedge clk);
    send_req(16'h0100);
    repeat (50) @(posedge clk);
    send_req(16'h0200);
    wait_done("pend_first");
    wait_done("pend_second");

    // reset mid-transaction in byte 1, bit 2 (0xC3 -> bit 0, SDA pulled)
    exp_q.push_back(8'h18);
    send_req(16'hC355);
    repeat (192) @(posedge clk);
    #2;
    check("pre_rst_busy",   {31'd0, busy},   32'd1);
    check("pre_rst_scl_oe", {31'd0, scl_oe}, 32'd1);
    check("pre_rst_sda_oe", {31'd0, sda_oe}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_scl_oe", {31'd0, scl_oe}, 32'd0);
    check("mid_rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("mid_rst_busy",   {31'd0, busy},   32'd0);
    check("mid_rst_done",   {31'd0, done},   32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    exp_write(16'h5A01, 1'b0);
    send_req(16'h5A01);
    wait_done("after_reset");

    // request in the DONE cycle starts a follow-on immediately
    exp_write(16'h0F0F, 1'b1);
    exp_write(16'hC3A5, 1'b0);
    send_req(16'h0F0F);
    wait_done("coinc_first");
    vcm_data = 16'hC3A5;
    wr_req   = 1'b1;
    @(posedge clk); #2;
    wr_req   = 1'b0;
    vcm_data = 16'($urandom_range(0, 65535));
    wait_done("coinc_second");

    repeat (10) @(posedge clk);
    check("bytes_outstanding", exp_q.size(), 32'd0);
    check("txns_outstanding",  exp_txn_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
